// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Holds the program counter, fetches instruction words from instruction memory
// with a req/ack handshake, presents the latched IR with a valid flag to the
// control unit, and applies the control unit's next-PC selection.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   TIMEOUT   cycles in REQ without mem_ack before a timeout fault (1..255)
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   pc_sel, pc_load         next-PC select (HOLD/PLUS4/JUMP/IN) applied on pc_load in VALID
//   k, pc_in                signed word offset for JUMP, register target for IN
//   mem_req, mem_addr       fetch request and address (= pc)
//   mem_ack, mem_rdata      memory data valid and instruction word
//   IR, ir_valid            latched instruction and its valid flag
//   pc, pc_plus4            current PC and link value
//   fault, fault_code       sticky fault flag, cause (01 timeout, 10 misaligned)
//
// Build option: define IFU_ALIGN_CHECK_EN to trap PCs with pc[1:0] != 0.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pc_sel,
  input  logic        pc_load,
  input  logic [31:0] k,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_PLUS4 = 2'b01;
  localparam logic [1:0] SEL_JUMP  = 2'b10;
  localparam logic [1:0] SEL_IN    = 2'b11;

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b01;
  localparam logic [1:0] CODE_MISALIGN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_VALID = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      pc_target;
  logic             boot_trap;
  logic             load_trap;
  logic             do_load;

  // PC-derived outputs: no combinational path from any input
  assign mem_addr = pc;
  assign pc_plus4 = pc + 32'd4;

  // A pc_load that actually moves the PC (HOLD stays in VALID without refetch)
  assign do_load = (state == ST_VALID) && pc_load && (pc_sel != SEL_HOLD);

  // Candidate next PC; k<<2 drops k[31:30], all math wraps modulo 2^32
  always_comb begin
    pc_target = pc;
    case (pc_sel)
      SEL_HOLD:  pc_target = pc;
      SEL_PLUS4: pc_target = pc_plus4;
      SEL_JUMP:  pc_target = pc + (k << 2);
      SEL_IN:    pc_target = pc_in;
      default:   pc_target = pc;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign boot_trap = (pc[1:0] != 2'b00);
  assign load_trap = (pc_target[1:0] != 2'b00);
`else
  assign boot_trap = 1'b0;
  assign load_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ack wins over timeout on the same edge
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        state_next = boot_trap ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_next = ST_VALID;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_next = ST_FAULT;
        end
      end
      ST_VALID: begin
        if (do_load) begin
          state_next = load_trap ? ST_FAULT : ST_REQ;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    mem_req  = 1'b0;
    ir_valid = 1'b0;
    fault    = 1'b0;
    case (state)
      ST_REQ:   mem_req  = 1'b1;
      ST_VALID: ir_valid = 1'b1;
      ST_FAULT: fault    = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: PC, IR, wait counter and fault cause
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      IR         <= 32'h0000_0000;
      wait_cnt   <= '0;
      fault_code <= CODE_NONE;
    end else begin
      if (do_load) begin
        pc <= pc_target;
      end

      if (state == ST_REQ && mem_ack) begin
        IR <= mem_rdata;
      end

      if (state == ST_REQ && !mem_ack) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      // Cause is captured once, on the transition into FAULT
      if (state != ST_FAULT && state_next == ST_FAULT) begin
        fault_code <= (state == ST_REQ) ? CODE_TIMEOUT : CODE_MISALIGN;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, wait-state fetches, branches,
// PC wrap, timeout/ack race, reset mid-fetch and the misaligned-PC path.
// Expected fetches (address, instruction) are queued when a fetch is
// requested and compared when ir_valid comes up.

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned TIMEOUT  = 15;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_PLUS4 = 2'b01;
  localparam logic [1:0] SEL_JUMP  = 2'b10;
  localparam logic [1:0] SEL_IN    = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_item_t;

  logic        clock;
  logic        reset;
  logic [1:0]  pc_sel;
  logic        pc_load;
  logic [31:0] k;
  logic [31:0] pc_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks;
  int n_errors;
  sb_item_t sb[$];

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pc_sel    (pc_sel),
    .pc_load   (pc_load),
    .k         (k),
    .pc_in     (pc_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .fault     (fault),
    .fault_code(fault_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory side: stays silent for 'waits' cycles, then acks with 'data'
  task automatic serve(input int waits, input logic [31:0] data);
    sb_item_t    exp;
    logic [31:0] addr0;
    int          req_cycles;
    req_cycles = 0;
    addr0      = mem_addr;
    for (int i = 0; i < waits; i++) begin
      if (mem_req === 1'b1 && mem_addr === addr0) req_cycles++;
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      tick();
    end
    if (mem_req === 1'b1 && mem_addr === addr0) req_cycles++;
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom();
    check("req_cycles", 32'(req_cycles), 32'(waits + 1));
    check("ir_valid_up", 32'(ir_valid), 32'd1);
    check("mem_req_down", 32'(mem_req), 32'd0);
    check("no_fault", 32'(fault), 32'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check("fetch_addr", addr0, exp.addr);
      check("ir_data", IR, exp.data);
    end
  endtask

  // One pc_load edge; control inputs are scrambled afterwards
  task automatic do_load(input logic [1:0] sel, input logic [31:0] kk,
                         input logic [31:0] pin, input logic [31:0] exp_pc);
    pc_load = 1'b1;
    pc_sel  = sel;
    k       = kk;
    pc_in   = pin;
    tick();
    pc_load = 1'b0;
    pc_sel  = 2'($urandom());
    k       = $urandom();
    pc_in   = $urandom();
    check("pc_after_load", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  task automatic load_fetch(input logic [1:0] sel, input logic [31:0] kk,
                            input logic [31:0] pin, input logic [31:0] exp_pc,
                            input int waits, input logic [31:0] data);
    do_load(sel, kk, pin, exp_pc);
    check("ir_valid_drop", 32'(ir_valid), 32'd0);
    check("req_issued", 32'(mem_req), 32'd1);
    check("mem_addr", mem_addr, exp_pc);
    sb.push_back('{addr: exp_pc, data: data});
    serve(waits, data);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    pc_sel    = SEL_HOLD;
    pc_load   = 1'b0;
    k         = '0;
    pc_in     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset values
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", IR, 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    tick();
    reset = 1'b0;

    // Zero-wait boot: IDLE->REQ, then ack on the first REQ edge
    tick();
    check("boot_req", 32'(mem_req), 32'd1);
    check("boot_addr", mem_addr, 32'h0);
    check("boot_not_valid", 32'(ir_valid), 32'd0);
    sb.push_back('{addr: 32'h0, data: 32'h5400_000C});
    serve(0, 32'h5400_000C);

    // Sequential run, three wait states per fetch
    load_fetch(SEL_PLUS4, 32'h0, 32'h0, 32'h4, 3, 32'hA000_0004);
    load_fetch(SEL_PLUS4, 32'h0, 32'h0, 32'h8, 3, 32'hA000_0008);
    load_fetch(SEL_PLUS4, 32'h0, 32'h0, 32'hC, 3, 32'hA000_000C);

    // Branches
    load_fetch(SEL_IN,   32'h0,         32'h100, 32'h100, 1, 32'hB000_0100);
    load_fetch(SEL_JUMP, 32'hFFFF_FFFE, 32'h0,   32'hF8,  2, 32'hB000_00F8);
    load_fetch(SEL_IN,   32'h0,         32'h40,  32'h40,  0, 32'hB000_0040);

    // HOLD: no refetch, ir_valid stays up, IR held
    do_load(SEL_HOLD, 32'h1234, 32'h800, 32'h40);
    check("hold_valid", 32'(ir_valid), 32'd1);
    check("hold_no_req", 32'(mem_req), 32'd0);
    check("hold_ir", IR, 32'hB000_0040);
    tick();
    check("hold_no_req2", 32'(mem_req), 32'd0);
    check("hold_valid2", 32'(ir_valid), 32'd1);

    // Wrap-around and offset truncation
    load_fetch(SEL_IN,    32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'hC000_FFFC);
    load_fetch(SEL_PLUS4, 32'h0,         32'h0,         32'h0,         1, 32'hC000_0000);
    load_fetch(SEL_JUMP,  32'h4000_0001, 32'h0,         32'h4,         0, 32'hC000_0004);

    // Ack on the TIMEOUT-th edge wins over the timeout
    load_fetch(SEL_PLUS4, 32'h0, 32'h0, 32'h8, int'(TIMEOUT) - 1, 32'hD000_0008);
    check("race_fault_code", 32'(fault_code), 32'd0);

    // No ack: fault on the TIMEOUT-th edge
    do_load(SEL_PLUS4, 32'h0, 32'h0, 32'hC);
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      mem_ack = 1'b0;
      tick();
    end
    check("to_still_req", 32'(mem_req), 32'd1);
    check("to_no_fault_yet", 32'(fault), 32'd0);
    tick();
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_code", 32'(fault_code), 32'd1);
    check("to_mem_req", 32'(mem_req), 32'd0);
    check("to_ir_valid", 32'(ir_valid), 32'd0);
    // Sticky: late ack and pc_load are ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    pc_load   = 1'b1;
    pc_sel    = SEL_IN;
    pc_in     = 32'h500;
    tick();
    mem_ack = 1'b0;
    pc_load = 1'b0;
    check("sticky_fault", 32'(fault), 32'd1);
    check("sticky_pc", pc, 32'hC);
    check("sticky_ir", IR, 32'hD000_0008);
    check("sticky_valid", 32'(ir_valid), 32'd0);

    // Reset clears the fault
    reset = 1'b1;
    tick();
    check("rst2_fault", 32'(fault), 32'd0);
    check("rst2_fault_code", 32'(fault_code), 32'd0);
    check("rst2_pc", pc, RESET_PC);
    reset = 1'b0;
    tick();
    sb.push_back('{addr: 32'h0, data: 32'hE000_0000});
    serve(1, 32'hE000_0000);

    // Reset mid-fetch at pc=0x20
    do_load(SEL_IN, 32'h0, 32'h20, 32'h20);
    tick();
    tick();
    check("mid_req", 32'(mem_req), 32'd1);
    check("mid_addr", mem_addr, 32'h20);
    reset = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_valid", 32'(ir_valid), 32'd0);
    // Late ack lands in IDLE and must not load IR
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0020;
    tick();
    mem_ack = 1'b0;
    check("late_ack_valid", 32'(ir_valid), 32'd0);
    check("late_ack_ir", IR, 32'h0);
    check("late_ack_req", 32'(mem_req), 32'd1);
    sb.push_back('{addr: 32'h0, data: 32'hF000_0000});
    serve(0, 32'hF000_0000);

    // Misaligned register target
`ifdef IFU_ALIGN_CHECK_EN
    do_load(SEL_IN, 32'h0, 32'h102, 32'h102);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_fault_code", 32'(fault_code), 32'd2);
    check("mis_no_req", 32'(mem_req), 32'd0);
    tick();
    check("mis_no_req2", 32'(mem_req), 32'd0);
`else
    load_fetch(SEL_IN, 32'h0, 32'h102, 32'h102, 2, 32'h0102_0102);
    check("mis_fault_code", 32'(fault_code), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
